// File: rtl/cordic_sincos.sv
// Iterative rotation-mode CORDIC: Q2.27 angle in, Q2.27 sine and cosine out.
// Define CORDIC_QUAD_FOLD_EN for a full [-pi, pi] input range; otherwise the angle is clamped to +/-pi/2.
module cordic_sincos #(
  parameter int unsigned ITER  = 16,
  parameter int unsigned WIDTH = 30
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] angle_in,
  output logic signed [WIDTH-1:0] sin_out,
  output logic signed [WIDTH-1:0] cos_out,
  output logic                    busy,
  output logic                    done
);

  localparam logic signed [WIDTH-1:0] KInit     = WIDTH'(81504109);
  localparam logic signed [WIDTH-1:0] Pi        = WIDTH'(421657428);
  localparam logic signed [WIDTH-1:0] NegPi     = WIDTH'(-421657428);
  localparam logic signed [WIDTH-1:0] HalfPi    = WIDTH'(210828714);
  localparam logic signed [WIDTH-1:0] NegHalfPi = WIDTH'(-210828714);
  localparam logic [4:0]              LastIter  = 5'(ITER - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] x_q, x_d;
  logic signed [WIDTH-1:0] y_q, y_d;
  logic signed [WIDTH-1:0] z_q, z_d;
  logic signed [WIDTH-1:0] sin_q, sin_d;
  logic signed [WIDTH-1:0] cos_q, cos_d;
  logic [4:0]              cnt_q, cnt_d;
  logic                    neg_q, neg_d;
  logic                    done_q, done_d;

  logic signed [WIDTH-1:0] clamped, z_load;
  logic                    neg_load;
  logic signed [WIDTH-1:0] x_shift, y_shift, atan_i;
  logic signed [WIDTH-1:0] x_rot, y_rot, z_rot;
  logic                    dir;
  logic                    load;

  // round(atan(2^-i) * 2^27); entries past the last legal iteration are zero.
  function automatic logic signed [WIDTH-1:0] atan_lut(input logic [4:0] idx);
    int unsigned v;
    case (idx)
      5'd0:    v = 105414357;
      5'd1:    v = 62229729;
      5'd2:    v = 32880480;
      5'd3:    v = 16690645;
      5'd4:    v = 8377711;
      5'd5:    v = 4192939;
      5'd6:    v = 2096981;
      5'd7:    v = 1048555;
      5'd8:    v = 524285;
      5'd9:    v = 262144;
      5'd10:   v = 131072;
      5'd11:   v = 65536;
      5'd12:   v = 32768;
      5'd13:   v = 16384;
      5'd14:   v = 8192;
      5'd15:   v = 4096;
      5'd16:   v = 2048;
      5'd17:   v = 1024;
      5'd18:   v = 512;
      5'd19:   v = 256;
      5'd20:   v = 128;
      5'd21:   v = 64;
      5'd22:   v = 32;
      5'd23:   v = 16;
      5'd24:   v = 8;
      5'd25:   v = 4;
      5'd26:   v = 2;
      default: v = 0;
    endcase
    return WIDTH'(v);
  endfunction

  // Angle conditioning at load time.
  always_comb begin
    clamped  = angle_in;
    z_load   = angle_in;
    neg_load = 1'b0;
`ifdef CORDIC_QUAD_FOLD_EN
    if (angle_in > Pi) begin
      clamped = Pi;
    end else if (angle_in < NegPi) begin
      clamped = NegPi;
    end
    // Outer half-planes rotate by pi and negate both results afterwards.
    if (clamped > HalfPi) begin
      z_load   = clamped - Pi;
      neg_load = 1'b1;
    end else if (clamped < NegHalfPi) begin
      z_load   = clamped + Pi;
      neg_load = 1'b1;
    end else begin
      z_load   = clamped;
    end
`else
    if (angle_in > HalfPi) begin
      clamped = HalfPi;
    end else if (angle_in < NegHalfPi) begin
      clamped = NegHalfPi;
    end
    z_load = clamped;
`endif
  end

  always_comb begin
    x_shift = x_q >>> cnt_q;
    y_shift = y_q >>> cnt_q;
    atan_i  = atan_lut(cnt_q);
    dir     = ~z_q[WIDTH-1];
    x_rot   = dir ? (x_q - y_shift) : (x_q + y_shift);
    y_rot   = dir ? (y_q + x_shift) : (y_q - x_shift);
    z_rot   = dir ? (z_q - atan_i)  : (z_q + atan_i);
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    sin_d   = sin_q;
    cos_d   = cos_q;
    done_d  = 1'b0;
    load    = 1'b0;

    case (state_q)
      StIdle: begin
        load = start;
      end
      StRun: begin
        x_d   = x_rot;
        y_d   = y_rot;
        z_d   = z_rot;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LastIter) begin
          state_d = StDone;
        end
      end
      StDone: begin
        sin_d  = neg_q ? -y_q : y_q;
        cos_d  = neg_q ? -x_q : x_q;
        done_d = 1'b1;
        // A start seen here chains straight into the next conversion.
        if (start) begin
          load = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (load) begin
      state_d = StRun;
      x_d     = KInit;
      y_d     = '0;
      z_d     = z_load;
      neg_d   = neg_load;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      sin_q   <= '0;
      cos_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      sin_q   <= sin_d;
      cos_q   <= cos_d;
      done_q  <= done_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign sin_out = sin_q;
  assign cos_out = cos_q;

endmodule

// File: tb/tb_cordic_sincos.sv
// Scoreboard bench for cordic_sincos: directed angles, ignored starts, chaining and abort.
module tb_cordic_sincos;

  localparam int ITER  = 16;
  localparam int WIDTH = 30;
  // Residual angle after ITER rotations is below atan(2^-(ITER-1)), plus truncation slack.
  localparam int TOL   = (1 << (27 - ITER + 1)) + 256;

  localparam int One     = 134217728;
  localparam int Pi      = 421657428;
  localparam int Pi6     = 70276238;
  localparam int Sin30   = 67108864;
  localparam int Cos30   = 116235962;
  localparam int Rt2h    = 94906266;

  logic                    clk;
  logic                    reset;
  logic                    start;
  logic signed [WIDTH-1:0] angle_in;
  logic signed [WIDTH-1:0] sin_out;
  logic signed [WIDTH-1:0] cos_out;
  logic                    busy;
  logic                    done;

  typedef struct {
    string name;
    int    s;
    int    c;
    int    cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  cordic_sincos #(
    .ITER (ITER),
    .WIDTH(WIDTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .angle_in(angle_in),
    .sin_out (sin_out),
    .cos_out (cos_out),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string nm, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic check_near(input string nm, input int act, input int req);
    int diff = act - req;
    tests++;
    if (diff > TOL || diff < -TOL) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d +/- %0d", nm, act, req, TOL);
    end
  endtask

  task automatic expect_result(input string nm, input int es, input int ec, input int at_cyc);
    exp_t e;
    e.name = nm;
    e.s    = es;
    e.c    = ec;
    e.cyc  = at_cyc;
    sb.push_back(e);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
        end else begin
          exp_t e = sb.pop_front();
          check_near({e.name, " sin"}, int'(sin_out), e.s);
          check_near({e.name, " cos"}, int'(cos_out), e.c);
          check_eq({e.name, " done_cycle"}, cyc, e.cyc);
        end
      end
    end
  endtask

  // Called at a negedge; leaves the bench one negedge after the accepting edge.
  task automatic issue(input string nm, input int ang, input int es, input int ec);
    angle_in = WIDTH'(ang);
    start    = 1'b1;
    expect_result(nm, es, ec, cyc + ITER + 2);
    @(negedge clk);
    start = 1'b0;
    check_eq({nm, " busy"}, int'(busy), 1);
  endtask

  task automatic drain();
    repeat (ITER + 4) @(negedge clk);
  endtask

  initial begin
    int c0;
    reset    = 1'b1;
    start    = 1'b0;
    angle_in = '0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check_eq("reset busy", int'(busy), 0);
    check_eq("reset done", int'(done), 0);
    check_eq("reset sin", int'(sin_out), 0);
    check_eq("reset cos", int'(cos_out), 0);
    reset = 1'b0;
    @(negedge clk);

    issue("zero", 0, 0, One);
    drain();
    issue("pi6", Pi6, Sin30, Cos30);
    drain();
`ifdef CORDIC_QUAD_FOLD_EN
    issue("pi", Pi, 0, -One);
    drain();
    issue("m3pi4", -316243071, -Rt2h, -Rt2h);
    drain();
    issue("over_pi", 500000000, 0, -One);
    drain();
`else
    issue("pi_clamp", Pi, One, 0);
    drain();
    issue("m3pi4_clamp", -316243071, -One, 0);
    drain();
    issue("over_pi_clamp", 500000000, One, 0);
    drain();
`endif

    // Extra starts mid-run must be ignored; the first angle's result is kept.
    issue("ignored_starts", -Pi6, -Sin30, Cos30);
    repeat (4) @(negedge clk);
    angle_in = WIDTH'(Pi);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    repeat (4) @(negedge clk);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    drain();

    // Start held across done: three chained conversions, each ITER+1 apart.
    c0       = cyc;
    angle_in = WIDTH'(Pi6);
    start    = 1'b1;
    expect_result("chain0", Sin30, Cos30, c0 + ITER + 2);
    @(negedge clk);
    angle_in = '0;
    expect_result("chain1", 0, One, c0 + 2 * ITER + 3);
    repeat (ITER + 1) @(negedge clk);
    angle_in = WIDTH'(-Pi6);
    expect_result("chain2", -Sin30, Cos30, c0 + 3 * ITER + 4);
    repeat (ITER + 1) @(negedge clk);
    start = 1'b0;
    drain();

    // Abort: reset in the middle of a run discards it.
    angle_in = WIDTH'(Pi6);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort busy", int'(busy), 0);
    check_eq("abort done", int'(done), 0);
    check_eq("abort sin", int'(sin_out), 0);
    check_eq("abort cos", int'(cos_out), 0);
    reset = 1'b0;
    repeat (ITER + 8) @(negedge clk);

    check_eq("pending results", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
